// File: rtl/tp2_pkg.sv
// rtl/tp2_pkg.sv - shared types and constants for the tp2 sequencer
package tp2_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_FIM = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Bit positions of the tp2 inputs inside a buffered word.
  localparam int TOM_B = 3;
  localparam int IN1_B = 2;
  localparam int IN2_B = 1;
  localparam int IN3_B = 0;

  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 8;

endpackage

// File: rtl/tp2_fila.sv
// rtl/tp2_fila.sv - DEPTH x 4 circular word buffer with count/full/empty
module tp2_fila
  import tp2_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [3:0]    push_data,
  input  logic          pop,
  output logic [3:0]    rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Word storage; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tp2_sequenciador.sv
// rtl/tp2_sequenciador.sv - replays a buffered burst into tp2 and waits for fim
module tp2_sequenciador
  import tp2_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       start,
  input  logic       fim,
  output logic       full,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ok,
  output logic       tom,
  output logic       in1,
  output logic       in2,
  output logic       in3
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    word_q, word_nxt;
  logic          ok_nxt, done_nxt, err_nxt, busy_nxt;

  logic          fila_push, fila_pop, fila_empty;
  logic [3:0]    fila_rdata;
  logic [AW:0]   fila_count;
  logic          accept_start;

  // A start in IDLE always drops a concurrent push, even if the start itself is ignored.
  assign fila_push    = push && (state == IDLE) && !start;
  assign accept_start = (state == IDLE) && start && !fila_empty;
  assign fila_pop     = accept_start || ((state == ISSUE) && (fila_count != '0));

  tp2_fila #(.DEPTH(DEPTH)) u_fila (
    .clock     (clock),
    .reset     (reset),
    .push      (fila_push),
    .push_data (push_data),
    .pop       (fila_pop),
    .rdata     (fila_rdata),
    .count     (fila_count),
    .full      (full),
    .empty     (fila_empty)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept_start) state_nxt = ISSUE;
      ISSUE:    if (fila_count == '0) state_nxt = WAIT_FIM;
      WAIT_FIM: if (fim || (timer == TMAX)) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the fim timer.
  always_comb begin
    ok_nxt    = 1'b0;
    word_nxt  = 4'b0000;
    done_nxt  = 1'b0;
    err_nxt   = err;
    timer_nxt = timer;
    busy_nxt  = (state_nxt == ISSUE) || (state_nxt == WAIT_FIM);
    case (state)
      IDLE: begin
        if (accept_start) begin
          ok_nxt   = 1'b1;
          word_nxt = fila_rdata;
          err_nxt  = 1'b0;
        end
      end
      ISSUE: begin
        if (fila_count != '0) begin
          ok_nxt   = 1'b1;
          word_nxt = fila_rdata;
        end else begin
          timer_nxt = '0;
        end
      end
      WAIT_FIM: begin
        if (fim) begin
          done_nxt = 1'b1;
        end else if (timer == TMAX) begin
          done_nxt = 1'b1;
          err_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and timer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ok     <= 1'b0;
      word_q <= 4'b0000;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      timer  <= '0;
    end else begin
      ok     <= ok_nxt;
      word_q <= word_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      busy   <= busy_nxt;
      timer  <= timer_nxt;
    end
  end

  assign tom = word_q[TOM_B];
  assign in1 = word_q[IN1_B];
  assign in2 = word_q[IN2_B];
  assign in3 = word_q[IN3_B];

endmodule
